// File: rtl/rot_seq_pkg.sv
// Shared types and constants for the rotate sequencer.
package rot_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned AMT_W  = 3;

  localparam logic LR_RIGHT = 1'b0;
  localparam logic LR_LEFT  = 1'b1;

endpackage

// File: rtl/rot_seq.sv
// Command front-end for an external 8-bit barrel rotator: seeds an operand, then
// emits one rotated byte per beat on a valid/ready port, feeding each result back.
module rot_seq
  import rot_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_lr,
  input  logic [CNT_W-1:0]  in_count,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  remaining,
  output logic [DATA_W-1:0] sh_a,
  output logic [AMT_W-1:0]  sh_amt,
  output logic              sh_lr,
  input  logic [DATA_W-1:0] sh_y
);

  state_e            state;
  logic [DATA_W-1:0] cur;
  logic [AMT_W-1:0]  amt;
  logic              lr;

  assign in_ready = (state == IDLE);
  assign sh_a     = cur;
  assign sh_amt   = amt;
  assign sh_lr    = lr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      amt       <= '0;
      lr        <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      remaining <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // A zero-length command is consumed without producing beats.
          if (in_valid && in_count != '0) begin
            cur       <= in_data;
            amt       <= in_amt;
            lr        <= in_lr;
            remaining <= in_count;
            state     <= ROT;
          end
        end
        ROT: begin
          if (abort) begin
            out_valid <= 1'b0;
            remaining <= '0;
            state     <= IDLE;
          end else begin
            cur       <= sh_y;
            out_data  <= sh_y;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // Abort wins over a same-cycle handshake; that beat is not delivered.
          if (abort) begin
            out_valid <= 1'b0;
            remaining <= '0;
            state     <= IDLE;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (remaining <= CNT_W'(1)) begin
              remaining <= '0;
              state     <= IDLE;
            end else begin
              remaining <= remaining - CNT_W'(1);
              state     <= ROT;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          remaining <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rot_seq.sv
// Self-checking bench for rot_seq with a behavioural rotator on the sh_* port.
module tb_rot_seq;
  import rot_seq_pkg::*;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = '0;
  logic [2:0]       in_amt = '0;
  logic             in_lr = 1'b0;
  logic [CNT_W-1:0] in_count = '0;
  logic             abort = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_data;
  logic [CNT_W-1:0] remaining;
  logic [7:0]       sh_a;
  logic [2:0]       sh_amt;
  logic             sh_lr;
  logic [7:0]       sh_y;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  rot_seq #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_lr     (in_lr),
    .in_count  (in_count),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .remaining (remaining),
    .sh_a      (sh_a),
    .sh_amt    (sh_amt),
    .sh_lr     (sh_lr),
    .sh_y      (sh_y)
  );

  // Bit-placement rotator standing in for the real combinational block.
  always_comb begin
    sh_y = '0;
    for (int i = 0; i < 8; i++) begin
      if (sh_lr == LR_LEFT) sh_y[(i + int'(sh_amt)) % 8] = sh_a[i];
      else                  sh_y[(i + 8 - int'(sh_amt)) % 8] = sh_a[i];
    end
  end

  // Beat b is the seed rotated left by b times the per-beat left shift, modulo 8.
  function automatic logic [7:0] expect_beat(input logic [7:0] seed, input int amt,
                                             input logic lr, input int b);
    int          left;
    int          s;
    logic [15:0] w;
    left = (lr == LR_RIGHT) ? (8 - amt) % 8 : amt;
    s    = (left * b) % 8;
    w    = {8'h00, seed} << s;
    return w[7:0] | w[15:8];
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // stall < 0 picks a random stall of 0..3 cycles per beat; abort_beat 0 means none.
  task automatic run_cmd(input logic [7:0] seed, input int amt, input logic lr, input int count,
                         input int stall, input int abort_beat, input logic abort_with_cmd);
    int         n;
    int         st;
    logic [7:0] exp;
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_data  = seed;
    in_amt   = amt[2:0];
    in_lr    = lr;
    in_count = count[CNT_W-1:0];
    abort    = abort_with_cmd;
    tick();
    in_valid = 1'b0;
    abort    = 1'b0;
    in_data  = 8'($urandom);
    if (count == 0) begin
      repeat (4) begin
        check("zero_valid", out_valid, 0);
        check("zero_ready", in_ready, 1);
        check("zero_rem", remaining, 0);
        tick();
      end
      return;
    end
    for (int b = 1; b <= count; b++) begin
      n = 0;
      while (!out_valid && n < 8) begin
        tick();
        n++;
      end
      exp = expect_beat(seed, amt, lr, b);
      check("beat_valid", out_valid, 1);
      check("beat_latency", n, 1);
      check("beat_data", out_data, exp);
      check("beat_rem", remaining, count - b + 1);
      check("sh_a", sh_a, exp);
      check("sh_amt", sh_amt, amt);
      check("sh_lr", sh_lr, lr);
      if (b == abort_beat) begin
        abort     = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        tick();
        abort     = 1'b0;
        out_ready = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_rem", remaining, 0);
        check("abort_ready", in_ready, 1);
        return;
      end
      st = (stall < 0) ? $urandom_range(0, 3) : stall;
      repeat (st) begin
        out_ready = 1'b0;
        tick();
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, exp);
        check("hold_rem", remaining, count - b + 1);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("post_valid", out_valid, 0);
      check("post_rem", remaining, count - b);
      check("post_ready", in_ready, b == count);
    end
  endtask

  initial begin
    int start;
    repeat (2) tick();
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_rem", remaining, 0);
    check("rst_data", out_data, 0);
    check("rst_sh_a", sh_a, 0);
    check("rst_sh_amt", sh_amt, 0);
    check("rst_sh_lr", sh_lr, 0);
    rst_n = 1'b1;
    tick();

    start = cyc;
    run_cmd(8'h81, 1, LR_RIGHT, 3, 0, 0, 1'b0);
    check("idle_after_accept", cyc - start - 1, 6);
    run_cmd(8'h01, 3, LR_LEFT, 4, 0, 0, 1'b0);
    run_cmd(8'hF0, 4, LR_RIGHT, 2, 5, 0, 1'b0);
    run_cmd(8'h5A, 2, LR_LEFT, 0, 0, 0, 1'b0);
    run_cmd(8'hA5, 0, LR_RIGHT, 2, 1, 0, 1'b0);
    run_cmd(8'h3C, 1, LR_LEFT, 5, 1, 2, 1'b0);
    run_cmd(8'h96, 5, LR_RIGHT, 3, 0, 0, 1'b1);

    // Asynchronous reset in the middle of a command.
    in_valid = 1'b1;
    in_data  = 8'h81;
    in_amt   = 3'd1;
    in_lr    = LR_RIGHT;
    in_count = 8'd3;
    tick();
    in_valid = 1'b0;
    tick();
    check("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_rem", remaining, 0);
    check("mid_rst_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    run_cmd(8'h81, 1, LR_RIGHT, 3, 0, 0, 1'b0);

    for (int k = 0; k < 25; k++) begin
      int cnt;
      int ab;
      cnt = $urandom_range(0, 6);
      ab  = (cnt > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, cnt) : 0;
      run_cmd(8'($urandom), $urandom_range(0, 7), 1'($urandom_range(0, 1)), cnt, -1, ab,
              $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
